i2s_sample_receiver: RTL and testbench

Deserializes stereo audio from a codec ADC's I2S-style serial stream (bclk, lrck, sdata) into parallel left/right sample pairs in the `in_clk` domain. It is the receive counterpart of the 48 kHz audio output path. It sits between the codec pins and the audio processing logic, and emits one `sample_valid` pulse per stereo frame.

---
 rtl/i2s_sample_receiver.sv | 162 ++++++++++++++++
 tb/tb_i2s_sample_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_receiver.sv
// I2S-style receiver: synchronizes bclk/lrck/sdata into in_clk and deserializes stereo sample pairs.
// Optional macro I2S_RX_ERROR_COUNT_EN adds a saturating 8-bit short-word counter (err_count).
module i2s_sample_receiver #(
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    in_clk,
  input  logic                    resetn,
  input  logic                    bclk_in,
  input  logic                    lrck_in,
  input  logic                    sdata_in,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    frame_error
`ifdef I2S_RX_ERROR_COUNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              bclk_sync_q, bclk_sync_d;
  logic [1:0]              lrck_sync_q, lrck_sync_d;
  logic [1:0]              sdata_sync_q, sdata_sync_d;
  logic                    lrck_prev_q, lrck_prev_d;
  logic                    primed_q, primed_d;
  logic                    chan_q, chan_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    frame_error_q, frame_error_d;
`ifdef I2S_RX_ERROR_COUNT_EN
  logic [7:0]              err_count_q, err_count_d;
`endif

  logic                    bit_ev;
  logic                    lrck_s;
  logic                    sdata_s;
  logic [SAMPLE_WIDTH-1:0] shift_next;

  // Next-state logic: everything except the synchronizers advances only on a bit event.
  always_comb begin
    bclk_sync_d    = {bclk_sync_q[1:0], bclk_in};
    lrck_sync_d    = {lrck_sync_q[0], lrck_in};
    sdata_sync_d   = {sdata_sync_q[0], sdata_in};
    state_d        = state_q;
    lrck_prev_d    = lrck_prev_q;
    primed_d       = primed_q;
    chan_d         = chan_q;
    count_d        = count_q;
    shift_d        = shift_q;
    hold_d         = hold_q;
    hold_valid_d   = hold_valid_q;
    left_d         = left_q;
    right_d        = right_q;
    sample_valid_d = 1'b0;
    frame_error_d  = 1'b0;

    bit_ev     = bclk_sync_q[1] & ~bclk_sync_q[2];
    lrck_s     = lrck_sync_q[1];
    sdata_s    = sdata_sync_q[1];
    shift_next = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};

    if (bit_ev) begin
      lrck_prev_d = lrck_s;
      primed_d    = 1'b1;
      // The first bit event after reset only records lrck so a mid-slot start is not a boundary.
      if (primed_q && (lrck_s != lrck_prev_q)) begin
        if (state_q == ST_SHIFT) begin
          frame_error_d = 1'b1;
          hold_valid_d  = 1'b0;
          hold_d        = '0;
        end
        state_d = ST_SHIFT;
        chan_d  = lrck_s;
        count_d = '0;
        shift_d = '0;
      end else if (state_q == ST_SHIFT) begin
        shift_d = shift_next;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(SAMPLE_WIDTH - 1)) begin
          state_d = ST_WAIT;
          if (!chan_q) begin
            hold_d       = shift_next;
            hold_valid_d = 1'b1;
          end else if (hold_valid_q) begin
            left_d         = hold_q;
            right_d        = shift_next;
            sample_valid_d = 1'b1;
            hold_valid_d   = 1'b0;
          end
        end
      end
    end

`ifdef I2S_RX_ERROR_COUNT_EN
    err_count_d = err_count_q;
    if (frame_error_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge in_clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      bclk_sync_q    <= '0;
      lrck_sync_q    <= '0;
      sdata_sync_q   <= '0;
      lrck_prev_q    <= 1'b0;
      primed_q       <= 1'b0;
      chan_q         <= 1'b0;
      count_q        <= '0;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      left_q         <= '0;
      right_q        <= '0;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef I2S_RX_ERROR_COUNT_EN
      err_count_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bclk_sync_q    <= bclk_sync_d;
      lrck_sync_q    <= lrck_sync_d;
      sdata_sync_q   <= sdata_sync_d;
      lrck_prev_q    <= lrck_prev_d;
      primed_q       <= primed_d;
      chan_q         <= chan_d;
      count_q        <= count_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      hold_valid_q   <= hold_valid_d;
      left_q         <= left_d;
      right_q        <= right_d;
      sample_valid_q <= sample_valid_d;
      frame_error_q  <= frame_error_d;
`ifdef I2S_RX_ERROR_COUNT_EN
      err_count_q    <= err_count_d;
`endif
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = sample_valid_q;
  assign frame_error  = frame_error_q;
`ifdef I2S_RX_ERROR_COUNT_EN
  assign err_count    = err_count_q;
`endif

endmodule

// File: tb/tb_i2s_sample_receiver.sv
// Directed bench for i2s_sample_receiver: drives I2S slots bit by bit and checks pairs, errors and reset.
module tb_i2s_sample_receiver;

  logic        in_clk;
  logic        resetn;
  logic        bclk_in;
  logic        lrck_in;
  logic        sdata_in;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic        frame_error;
`ifdef I2S_RX_ERROR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int valid_long = 0;
  int ferr_long = 0;
  int overlap = 0;
  int exp_valid = 0;
  int exp_ferr = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;

  i2s_sample_receiver #(.SAMPLE_WIDTH(16)) dut (
    .in_clk       (in_clk),
    .resetn       (resetn),
    .bclk_in      (bclk_in),
    .lrck_in      (lrck_in),
    .sdata_in     (sdata_in),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
`ifdef I2S_RX_ERROR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial begin
    in_clk = 1'b0;
    forever #10 in_clk = ~in_clk;
  end

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge in_clk) begin
    if (sample_valid) valid_cnt++;
    if (frame_error) ferr_cnt++;
    if (sample_valid && prev_valid) valid_long++;
    if (frame_error && prev_ferr) ferr_long++;
    if (sample_valid && frame_error) overlap++;
    prev_valid = sample_valid;
    prev_ferr  = frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    lrck_in  = lr;
    sdata_in = d;
    bclk_in  = 1'b0;
    #80;
    bclk_in  = 1'b1;
    #80;
  endtask

  // Slot bit 0 is the delay slot (junk 1), bits 1..16 carry the word MSB first, rest are padding.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int slot_len);
    logic d;
    for (int i = 0; i < slot_len; i++) begin
      if (i == 0) d = 1'b1;
      else if (i <= 16) d = w[16-i];
      else d = 1'b0;
      send_bit(lr, d);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot_len);
    send_slot(1'b0, l, slot_len);
    send_slot(1'b1, r, slot_len);
    #100;
  endtask

  initial begin
    logic [15:0] w;
    resetn   = 1'b0;
    bclk_in  = 1'b0;
    lrck_in  = 1'b0;
    sdata_in = 1'b0;
    #107;
    check("rst_left", 32'(left_sample), 32'h0);
    check("rst_right", 32'(right_sample), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_ferr", 32'(frame_error), 32'h0);
`ifdef I2S_RX_ERROR_COUNT_EN
    check("rst_errcnt", 32'(err_count), 32'h0);
`endif
    resetn = 1'b1;
    #43;

    // Start in the middle of a right slot.
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    #100;
    check("startup_no_valid", 32'(valid_cnt), 32'd0);
    check("startup_left_zero", 32'(left_sample), 32'h0);
    check("startup_right_zero", 32'(right_sample), 32'h0);

    send_frame(16'hA5C3, 16'h1234, 32);
    exp_valid++;
    check("nom1_valid_cnt", 32'(valid_cnt), 32'(exp_valid));
    check("nom1_left", 32'(left_sample), 32'hA5C3);
    check("nom1_right", 32'(right_sample), 32'h1234);
    check("nom1_no_ferr", 32'(ferr_cnt), 32'd0);

    send_frame(16'hA5C3, 16'h1234, 32);
    exp_valid++;
    check("nom2_valid_cnt", 32'(valid_cnt), 32'(exp_valid));
    check("nom2_no_ferr", 32'(ferr_cnt), 32'd0);

    // Short word: lrck toggles after 10 left bits.
    send_slot(1'b0, 16'hFFFF, 11);
    send_slot(1'b1, 16'h5555, 32);
    #100;
    exp_ferr++;
    check("short_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
    check("short_no_valid", 32'(valid_cnt), 32'(exp_valid));
    check("short_left_held", 32'(left_sample), 32'hA5C3);
    check("short_right_held", 32'(right_sample), 32'h1234);
`ifdef I2S_RX_ERROR_COUNT_EN
    check("short_errcnt", 32'(err_count), 32'd1);
`endif
    send_frame(16'h0F0F, 16'hF0F0, 32);
    exp_valid++;
    check("after_short_valid", 32'(valid_cnt), 32'(exp_valid));
    check("after_short_left", 32'(left_sample), 32'h0F0F);
    check("after_short_right", 32'(right_sample), 32'hF0F0);

`ifdef I2S_RX_ERROR_COUNT_EN
    // 300 alternating 3-bit slots: 299 short words here plus one more at the next left delay slot.
    for (int k = 0; k < 300; k++) send_slot(1'((k % 2) != 0), 16'h0000, 3);
    #100;
    check("sat_errcnt", 32'(err_count), 32'd255);
    exp_ferr += 300;
`endif

    send_frame(16'h1111, 16'h2222, 32);
    exp_valid++;
    check("f1_left", 32'(left_sample), 32'h1111);
    check("f1_right", 32'(right_sample), 32'h2222);
`ifdef I2S_RX_ERROR_COUNT_EN
    check("sat_hold_errcnt", 32'(err_count), 32'd255);
`endif

    // Frame 2: reset during the 8th right data bit.
    send_slot(1'b0, 16'h3333, 32);
    w = 16'h4444;
    send_bit(1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) send_bit(1'b1, w[16-i]);
    lrck_in  = 1'b1;
    sdata_in = w[8];
    bclk_in  = 1'b0;
    #40;
    resetn = 1'b0;
    #5;
    check("midrst_left", 32'(left_sample), 32'h0);
    check("midrst_right", 32'(right_sample), 32'h0);
    check("midrst_valid", 32'(sample_valid), 32'h0);
`ifdef I2S_RX_ERROR_COUNT_EN
    check("midrst_errcnt", 32'(err_count), 32'd0);
`endif
    #20;
    resetn = 1'b1;
    #15;
    bclk_in = 1'b1;
    #80;
    for (int i = 9; i < 32; i++) send_bit(1'b1, 1'b0);
    #100;
    check("postrst_no_valid", 32'(valid_cnt), 32'(exp_valid));
    send_frame(16'h7FFF, 16'h8000, 32);
    exp_valid++;
    check("postrst_valid_cnt", 32'(valid_cnt), 32'(exp_valid));
    check("postrst_left", 32'(left_sample), 32'h7FFF);
    check("postrst_right", 32'(right_sample), 32'h8000);

    // Minimum 17-bit slots.
    for (int f = 0; f < 3; f++) begin
      send_frame(16'hFFFF, 16'h0001, 17);
      exp_valid++;
      check("minslot_valid_cnt", 32'(valid_cnt), 32'(exp_valid));
      check("minslot_left", 32'(left_sample), 32'hFFFF);
      check("minslot_right", 32'(right_sample), 32'h0001);
    end
`ifdef I2S_RX_ERROR_COUNT_EN
    check("minslot_errcnt", 32'(err_count), 32'd0);
`endif

    check("total_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("valid_one_cycle", 32'(valid_long), 32'd0);
    check("ferr_one_cycle", 32'(ferr_long), 32'd0);
    check("valid_ferr_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
